// File: rtl/digit_lock_pkg.sv
// Shared types and constants for the keypad code lock.
// State encoding, digit width and a small elaboration-time helper.
package digit_lock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digit_lock_if.sv
// Keypad-side bus of the code lock: digit stream and clear in, lock status out.
// The master drives digits (keypad/bench); the slave is the lock itself.
interface digit_lock_if #(
  parameter int IDX_W  = 3,
  parameter int FCNT_W = 2
);
  logic [3:0]        digit_in;
  logic              digit_vld;
  logic              clear;
  logic              unlocked;
  logic              locked_out;
  logic              fail_pulse;
  logic [FCNT_W-1:0] fail_cnt;
  logic [IDX_W-1:0]  digit_idx;

  modport master (
    output digit_in, digit_vld, clear,
    input  unlocked, locked_out, fail_pulse, fail_cnt, digit_idx
  );

  modport slave (
    input  digit_in, digit_vld, clear,
    output unlocked, locked_out, fail_pulse, fail_cnt, digit_idx
  );
endinterface

// File: rtl/digit_lock_nibble_match.sv
// Combinational equality of one entered digit against one code nibble.
// Zero latency, no state, no backpressure.
import digit_lock_pkg::*;

module nibble_match (
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] code_nib,
  output logic               eq
);
  assign eq = (digit == code_nib);
endmodule

// File: rtl/digit_lock.sv
// Keypad code lock: collects CODE_LEN digits, unlocks for a window or counts a failure.
// Outputs registered, one edge after the final digit; no backpressure. DIGIT_LOCK_TIMEOUT_EN adds an entry idle timeout.
import digit_lock_pkg::*;

module digit_lock #(
  parameter int                          CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          UNLOCK_CYCLES  = 8,
  parameter int                          LOCKOUT_CYCLES = 16
`ifdef DIGIT_LOCK_TIMEOUT_EN
  , parameter int                        ENTRY_TIMEOUT  = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  digit_lock_if.slave  bus
);

  localparam int IDXW = $clog2(CODE_LEN + 1);
  localparam int FCW  = $clog2(MAX_FAIL + 1);
`ifdef DIGIT_LOCK_TIMEOUT_EN
  localparam int TMAX = max_int(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES), ENTRY_TIMEOUT);
`else
  localparam int TMAX = max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES);
`endif
  localparam int TW   = $clog2(TMAX + 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   digit_idx_q, digit_idx_d;
  logic              mism_q, mism_d;
  logic [FCW-1:0]    fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic              fail_pulse_q, fail_pulse_d;

  logic [DIGIT_W-1:0] code_nib;
  logic               eq;
  logic               mism_acc;
  logic               last_digit;
  logic               fail_evt;
  logic [FCW-1:0]     fail_next;

  always_comb begin
    code_nib = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_idx_q == IDXW'(i)) code_nib = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  nibble_match u_match (
    .digit    (bus.digit_in),
    .code_nib (code_nib),
    .eq       (eq)
  );

  assign mism_acc   = mism_q | ~eq;
  assign last_digit = (digit_idx_q == IDXW'(CODE_LEN - 1));
  assign fail_next  = fail_cnt_q + FCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digit_idx_q  <= '0;
      mism_q       <= 1'b0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_idx_q  <= digit_idx_d;
      mism_q       <= mism_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    mism_d      = mism_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    fail_evt    = 1'b0;

    case (state_q)
      IDLE, ENTRY: begin
        // clear wins over a simultaneous digit; in IDLE it is a no-op apart from dropping the digit
        if (bus.clear) begin
          state_d     = IDLE;
          digit_idx_d = '0;
          mism_d      = 1'b0;
          timer_d     = '0;
        end else if (bus.digit_vld) begin
          timer_d = '0;
          if (last_digit) begin
            digit_idx_d = '0;
            mism_d      = 1'b0;
            if (mism_acc) begin
              fail_evt = 1'b1;
            end else begin
              state_d    = UNLOCKED;
              fail_cnt_d = '0;
            end
          end else begin
            state_d     = ENTRY;
            digit_idx_d = digit_idx_q + IDXW'(1);
            mism_d      = mism_acc;
          end
        end
`ifdef DIGIT_LOCK_TIMEOUT_EN
        else if (state_q == ENTRY) begin
          if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
            digit_idx_d = '0;
            mism_d      = 1'b0;
            timer_d     = '0;
            fail_evt    = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
`endif
      end
      UNLOCKED: begin
        if (bus.clear || timer_q == TW'(UNLOCK_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completed mismatch and timeout abandonment share one failure path
    if (fail_evt) begin
      fail_cnt_d = fail_next;
      state_d    = (fail_next == FCW'(MAX_FAIL)) ? LOCKOUT : IDLE;
    end
  end

  always_comb begin
    unlocked_d   = (state_d == UNLOCKED);
    locked_out_d = (state_d == LOCKOUT);
    fail_pulse_d = fail_evt;
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.digit_idx  = digit_idx_q;

endmodule

// File: tb/tb_digit_lock.sv
// Directed bench for digit_lock with CODE=1234, MAX_FAIL=3, UNLOCK=8, LOCKOUT=16.
module tb_digit_lock;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cnt;

  digit_lock_if bus ();

  digit_lock dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    logic [3:0] ds [4];
    ds[0] = a; ds[1] = b; ds[2] = c; ds[3] = d;
    for (int i = 0; i < 4; i++) begin
      bus.digit_in  = ds[i];
      bus.digit_vld = 1'b1;
      tick();
    end
    bus.digit_vld = 1'b0;
  endtask

  task automatic end_unlock();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.digit_in  = 4'd0;
    bus.digit_vld = 1'b0;
    bus.clear     = 1'b0;
    #23;
    chk("rst_unlocked", 32'(bus.unlocked), 32'd0);
    chk("rst_locked_out", 32'(bus.locked_out), 32'd0);
    chk("rst_fail_pulse", 32'(bus.fail_pulse), 32'd0);
    chk("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("rst_digit_idx", 32'(bus.digit_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // Correct code: unlocked for exactly 8 cycles
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("ok_unlocked", 32'(bus.unlocked), 32'd1);
    chk("ok_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("ok_digit_idx", 32'(bus.digit_idx), 32'd0);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.unlocked) break;
      cnt++;
    end
    chk("unlock_width", 32'(cnt), 32'd8);
    chk("after_unlock_digit_idx", 32'(bus.digit_idx), 32'd0);

    // Wrong last digit, then correct code
    code4(4'd1, 4'd2, 4'd3, 4'd5);
    chk("bad_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    chk("bad_fail_cnt", 32'(bus.fail_cnt), 32'd1);
    chk("bad_unlocked", 32'(bus.unlocked), 32'd0);
    tick();
    chk("fail_pulse_one_cycle", 32'(bus.fail_pulse), 32'd0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("retry_unlocked", 32'(bus.unlocked), 32'd1);
    chk("retry_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    end_unlock();
    chk("clear_ends_unlock", 32'(bus.unlocked), 32'd0);

    // Wrong first digit only
    code4(4'd0, 4'd2, 4'd3, 4'd4);
    chk("first_bad_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    chk("first_bad_fail_cnt", 32'(bus.fail_cnt), 32'd1);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("first_bad_retry_unlocked", 32'(bus.unlocked), 32'd1);
    end_unlock();

    // Three failures force a 16-cycle lockout that ignores digits
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("lk_fail_cnt1", 32'(bus.fail_cnt), 32'd1);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("lk_fail_cnt2", 32'(bus.fail_cnt), 32'd2);
    chk("lk_not_yet", 32'(bus.locked_out), 32'd0);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("lk_locked_out", 32'(bus.locked_out), 32'd1);
    chk("lk_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    cnt = 1;
    bus.digit_vld = 1'b1;
    bus.clear     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.digit_in = 4'(i + 1);
      tick();
      if (!bus.locked_out) break;
      cnt++;
    end
    bus.digit_vld = 1'b0;
    chk("lockout_width", 32'(cnt), 32'd16);
    chk("lk_after_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("lk_after_digit_idx", 32'(bus.digit_idx), 32'd0);
    chk("lk_after_unlocked", 32'(bus.unlocked), 32'd0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("lk_after_unlock", 32'(bus.unlocked), 32'd1);
    end_unlock();

    // clear with a simultaneous digit abandons the entry
    bus.digit_in = 4'd1; bus.digit_vld = 1'b1; tick();
    chk("entry_idx1", 32'(bus.digit_idx), 32'd1);
    bus.digit_in = 4'd2; tick();
    chk("entry_idx2", 32'(bus.digit_idx), 32'd2);
    bus.digit_in = 4'd3; bus.clear = 1'b1; tick();
    bus.digit_vld = 1'b0; bus.clear = 1'b0;
    chk("clr_digit_idx", 32'(bus.digit_idx), 32'd0);
    chk("clr_fail_pulse", 32'(bus.fail_pulse), 32'd0);
    chk("clr_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("clr_then_unlock", 32'(bus.unlocked), 32'd1);

    // Async reset in the third unlocked cycle
    tick(); tick();
    chk("pre_rst_unlocked", 32'(bus.unlocked), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_unlock_unlocked", 32'(bus.unlocked), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Async reset mid-entry with a failure count and a set mismatch flag
    code4(4'd1, 4'd2, 4'd3, 4'd7);
    chk("pre_rst_fail_cnt", 32'(bus.fail_cnt), 32'd1);
    bus.digit_in = 4'd9; bus.digit_vld = 1'b1; tick();
    bus.digit_in = 4'd2; tick();
    bus.digit_vld = 1'b0;
    chk("pre_rst_digit_idx", 32'(bus.digit_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_entry_digit_idx", 32'(bus.digit_idx), 32'd0);
    chk("rst_entry_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("rst_entry_fail_pulse", 32'(bus.fail_pulse), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("rst_entry_then_unlock", 32'(bus.unlocked), 32'd1);
    end_unlock();

    // Idle gap inside an entry
    bus.digit_in = 4'd1; bus.digit_vld = 1'b1; tick();
    bus.digit_vld = 1'b0;
`ifdef DIGIT_LOCK_TIMEOUT_EN
    repeat (31) tick();
    chk("to_not_yet_pulse", 32'(bus.fail_pulse), 32'd0);
    chk("to_not_yet_idx", 32'(bus.digit_idx), 32'd1);
    tick();
    chk("to_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    chk("to_fail_cnt", 32'(bus.fail_cnt), 32'd1);
    chk("to_digit_idx", 32'(bus.digit_idx), 32'd0);
    chk("to_locked_out", 32'(bus.locked_out), 32'd0);
`else
    repeat (40) tick();
    chk("idle_wait_idx", 32'(bus.digit_idx), 32'd1);
    chk("idle_wait_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      bus.digit_in  = 4'(i);
      bus.digit_vld = 1'b1;
      tick();
    end
    bus.digit_vld = 1'b0;
    chk("idle_wait_unlock", 32'(bus.unlocked), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
